// File: rtl/adpll_lock_detector_if.sv
// Status/sample bundle between the ADPLL phase detector side and the lock detector.
// Latency: none, wires only.
// Backpressure: none; the phase error is a continuous sample, status is level/pulse.
interface adpll_lock_detector_if #(
  parameter int PDET_WIDTH = 5
);
  logic                  enable_i;
  logic                  ref_clk_i;
  logic [PDET_WIDTH-1:0] error_i;
  logic                  locked_o;
  logic                  lock_lost_o;
  logic                  ref_lost_o;
  logic [1:0]            state_o;
  logic [7:0]            loss_count_o;

  // Driver of the control/sample inputs and consumer of status.
  modport master (
    output enable_i, ref_clk_i, error_i,
    input  locked_o, lock_lost_o, ref_lost_o, state_o, loss_count_o
  );

  // The lock detector itself.
  modport slave (
    input  enable_i, ref_clk_i, error_i,
    output locked_o, lock_lost_o, ref_lost_o, state_o, loss_count_o
  );
endinterface

// File: rtl/adpll_lock_detector.sv
// Hysteretic lock detector: samples the signed phase error on each synchronised ref edge.
// Latency: ref_clk_i rise to state_o change is 2-3 fpga_clk_i cycles (sync + edge + update).
// Backpressure: none; every ref edge is evaluated, missing edges raise ref_lost_o.
module adpll_lock_detector #(
  parameter int PDET_WIDTH   = 5,
  parameter int LOCK_THRESH  = 2,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int REF_TIMEOUT  = 4096
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_n_i,
  adpll_lock_detector_if.slave  bus
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam int TW = $clog2(REF_TIMEOUT + 1);

  localparam logic [GW-1:0]         GOOD_TARGET = GW'(LOCK_COUNT);
  localparam logic [BW-1:0]         BAD_TARGET  = BW'(UNLOCK_COUNT);
  localparam logic [TW-1:0]         TMO_LAST    = TW'(REF_TIMEOUT - 1);
  localparam logic [TW-1:0]         TMO_MAX     = TW'(REF_TIMEOUT);
  localparam logic [PDET_WIDTH-1:0] THRESH      = PDET_WIDTH'(LOCK_THRESH);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'b00,
    ST_ACQUIRE  = 2'b01,
    ST_LOCKED   = 2'b10,
    ST_SLIP     = 2'b11
  } state_t;

  state_t                state, state_n;
  logic [GW-1:0]         good_cnt, good_cnt_n;
  logic [BW-1:0]         bad_cnt, bad_cnt_n;
  logic                  lock_lost, lock_lost_n;
  logic [7:0]            loss_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic                  ref_lost;
  logic                  sync1, sync2, prev;
  logic                  ref_edge;
  logic                  expire;
  logic [PDET_WIDTH-1:0] err_mag;
  logic                  in_win;
  logic                  locked;

  // Bring the asynchronous reference into fpga_clk_i and keep one delayed copy for edge detection.
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= bus.ref_clk_i;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign ref_edge = sync2 & ~prev;

  // Magnitude in PDET_WIDTH unsigned bits: the most negative code maps to 2^(PDET_WIDTH-1),
  // which is always larger than any legal threshold and therefore out of window.
  assign err_mag = bus.error_i[PDET_WIDTH-1] ? (PDET_WIDTH'(0) - bus.error_i) : bus.error_i;
  assign in_win  = (err_mag <= THRESH);

  // An edge arriving in the expiry cycle suppresses the timeout; saturation makes expiry one-shot.
  assign expire = bus.enable_i & ~ref_edge & (tmo_cnt == TMO_LAST);

  // Reference watchdog: cycles since the last ref edge, saturating at the timeout value.
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      tmo_cnt <= '0;
    end else if (!bus.enable_i || ref_edge) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Sticky missing-reference flag, released by the next edge or by disabling the detector.
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      ref_lost <= 1'b0;
    end else if (!bus.enable_i) begin
      ref_lost <= 1'b0;
    end else if (expire) begin
      ref_lost <= 1'b1;
    end else if (ref_edge) begin
      ref_lost <= 1'b0;
    end
  end

  // State register plus the hysteresis counters and the registered loss pulse.
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      state     <= ST_UNLOCKED;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_n;
      good_cnt  <= good_cnt_n;
      bad_cnt   <= bad_cnt_n;
      lock_lost <= lock_lost_n;
    end
  end

  // Next-state logic; priority is disable, then timeout, then ref-edge evaluation.
  always_comb begin
    state_n     = state;
    good_cnt_n  = good_cnt;
    bad_cnt_n   = bad_cnt;
    lock_lost_n = 1'b0;
    if (!bus.enable_i) begin
      state_n    = ST_UNLOCKED;
      good_cnt_n = '0;
      bad_cnt_n  = '0;
    end else if (expire) begin
      state_n     = ST_UNLOCKED;
      good_cnt_n  = '0;
      bad_cnt_n   = '0;
      lock_lost_n = (state == ST_LOCKED) || (state == ST_SLIP);
    end else if (ref_edge) begin
      case (state)
        ST_UNLOCKED: begin
          if (in_win) begin
            if (LOCK_COUNT == 1) begin
              state_n    = ST_LOCKED;
              good_cnt_n = '0;
            end else begin
              state_n    = ST_ACQUIRE;
              good_cnt_n = GW'(1);
            end
          end
        end
        ST_ACQUIRE: begin
          if (!in_win) begin
            state_n    = ST_UNLOCKED;
            good_cnt_n = '0;
          end else if (good_cnt + GW'(1) == GOOD_TARGET) begin
            state_n    = ST_LOCKED;
            good_cnt_n = '0;
          end else begin
            good_cnt_n = good_cnt + GW'(1);
          end
        end
        ST_LOCKED: begin
          if (!in_win) begin
            if (UNLOCK_COUNT == 1) begin
              state_n     = ST_UNLOCKED;
              bad_cnt_n   = '0;
              lock_lost_n = 1'b1;
            end else begin
              state_n   = ST_SLIP;
              bad_cnt_n = BW'(1);
            end
          end
        end
        ST_SLIP: begin
          if (in_win) begin
            state_n   = ST_LOCKED;
            bad_cnt_n = '0;
          end else if (bad_cnt + BW'(1) == BAD_TARGET) begin
            state_n     = ST_UNLOCKED;
            bad_cnt_n   = '0;
            lock_lost_n = 1'b1;
          end else begin
            bad_cnt_n = bad_cnt + BW'(1);
          end
        end
        default: begin
          state_n    = ST_UNLOCKED;
          good_cnt_n = '0;
          bad_cnt_n  = '0;
        end
      endcase
    end
  end

  // Count loss events alongside the pulse; saturate and keep the value while disabled.
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      loss_cnt <= 8'd0;
    end else if (lock_lost_n && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end

  // Output decode: SLIP still reports lock so short error bursts do not glitch locked_o.
  always_comb begin
    locked = 1'b0;
    case (state)
      ST_LOCKED, ST_SLIP: locked = 1'b1;
      default:            locked = 1'b0;
    endcase
  end

  assign bus.locked_o     = locked;
  assign bus.state_o      = state;
  assign bus.lock_lost_o  = lock_lost;
  assign bus.ref_lost_o   = ref_lost;
  assign bus.loss_count_o = loss_cnt;

endmodule
